axis_width_converter: RTL and testbench

Parametrised AXI-Stream data-width converter for byte-oriented packet streams; generalises the fixed 64→8 adapter to any integer width ratio in either direction, plus equal-width pass-through. Sits between MAC/DMA datapaths and narrower or wider processing stages. Frame boundaries are preserved: tlast is asserted on the last output beat carrying valid bytes, never on a trailing empty segment.

---
 rtl/axis_width_converter_pkg.sv | 32 +++
 rtl/axis_width_converter_last_seg_find.sv | 24 ++
 rtl/axis_width_converter.sv | 246 ++++++++++++++++++++++++
 tb/tb_axis_width_converter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_width_converter_pkg.sv
// Shared types, width-ratio helpers and popcount for axis_width_converter.
// Build option: AXIS_WIDTH_CONVERTER_STATS_EN adds frame/byte statistics.
package axis_width_converter_pkg;

  typedef enum logic [1:0] {MODE_PASS, MODE_DOWN, MODE_UP} mode_e;
  typedef enum logic {ST_IDLE, ST_SEND} down_state_e;

  localparam int POPCOUNT_WIDTH = 64;

  function automatic mode_e calc_mode(input int in_w, input int out_w);
    if (in_w == out_w) return MODE_PASS;
    if (in_w > out_w) return MODE_DOWN;
    return MODE_UP;
  endfunction

  function automatic int calc_ratio(input int in_w, input int out_w);
    return (in_w >= out_w) ? in_w / out_w : out_w / in_w;
  endfunction

  // Segment index needs at least one bit, even for pass-through.
  function automatic int calc_seg_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  function automatic logic [31:0] popcount(input logic [POPCOUNT_WIDTH-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < POPCOUNT_WIDTH; i++) n = n + 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/axis_width_converter_last_seg_find.sv
// Priority encoder: highest output segment of a wide tkeep that has any byte set (0 if none).
module axis_last_seg_find #(
  parameter int KEEP_WIDTH = 8,
  parameter int SEGS       = 8,
  parameter int SEG_W      = 3
) (
  input  logic [KEEP_WIDTH-1:0] keep_i,
  output logic [SEG_W-1:0]      seg_o
);
  localparam int LANE = KEEP_WIDTH / SEGS;

  logic [SEGS-1:0] seg_nz;

  for (genvar gi = 0; gi < SEGS; gi++) begin : g_nz
    assign seg_nz[gi] = |keep_i[gi*LANE +: LANE];
  end

  always_comb begin
    seg_o = '0;
    for (int i = 0; i < SEGS; i++) begin
      if (seg_nz[i]) seg_o = SEG_W'(i);
    end
  end
endmodule

// File: rtl/axis_width_converter.sv
// AXI-Stream width converter: pass-through, down-size or up-size chosen from the width ratio.
// Build option: AXIS_WIDTH_CONVERTER_STATS_EN adds stat_frame_count / stat_byte_count.
module axis_width_converter
  import axis_width_converter_pkg::*;
#(
  parameter int IN_DATA_WIDTH  = 64,
  parameter int OUT_DATA_WIDTH = 8,
  parameter int IN_KEEP_WIDTH  = IN_DATA_WIDTH / 8,
  parameter int OUT_KEEP_WIDTH = OUT_DATA_WIDTH / 8,
  parameter int USER_WIDTH     = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [IN_DATA_WIDTH-1:0]  input_axis_tdata,
  input  logic [IN_KEEP_WIDTH-1:0]  input_axis_tkeep,
  input  logic                      input_axis_tvalid,
  output logic                      input_axis_tready,
  input  logic                      input_axis_tlast,
  input  logic [USER_WIDTH-1:0]     input_axis_tuser,
  output logic [OUT_DATA_WIDTH-1:0] output_axis_tdata,
  output logic [OUT_KEEP_WIDTH-1:0] output_axis_tkeep,
  output logic                      output_axis_tvalid,
  input  logic                      output_axis_tready,
  output logic                      output_axis_tlast,
  output logic [USER_WIDTH-1:0]     output_axis_tuser
`ifdef AXIS_WIDTH_CONVERTER_STATS_EN
  ,
  output logic [31:0]               stat_frame_count,
  output logic [31:0]               stat_byte_count
`endif
);
  localparam mode_e MODE  = calc_mode(IN_DATA_WIDTH, OUT_DATA_WIDTH);
  localparam int    RATIO = calc_ratio(IN_DATA_WIDTH, OUT_DATA_WIDTH);
  localparam int    SEG_W = calc_seg_width(RATIO);

  logic                      in_ready;
  logic                      out_valid, out_last;
  logic [OUT_DATA_WIDTH-1:0] out_data;
  logic [OUT_KEEP_WIDTH-1:0] out_keep;
  logic [USER_WIDTH-1:0]     out_user;

  // Ready is held low for as long as reset is asserted.
  assign input_axis_tready  = rst_n & in_ready;
  assign output_axis_tvalid = out_valid;
  assign output_axis_tdata  = out_data;
  assign output_axis_tkeep  = out_keep;
  assign output_axis_tlast  = out_last;
  assign output_axis_tuser  = out_user;

  if (MODE == MODE_PASS) begin : g_pass
    logic                      valid_q, last_q;
    logic [OUT_DATA_WIDTH-1:0] data_q;
    logic [OUT_KEEP_WIDTH-1:0] keep_q;
    logic [USER_WIDTH-1:0]     user_q;

    assign in_ready = !valid_q || output_axis_tready;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        data_q  <= '0;
        keep_q  <= '0;
        user_q  <= '0;
      end else if (in_ready) begin
        valid_q <= input_axis_tvalid;
        if (input_axis_tvalid) begin
          data_q <= input_axis_tdata;
          keep_q <= input_axis_tkeep;
          last_q <= input_axis_tlast;
          user_q <= input_axis_tlast ? input_axis_tuser : '0;
        end
      end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_keep  = keep_q;
    assign out_last  = last_q;
    assign out_user  = user_q;

  end else if (MODE == MODE_DOWN) begin : g_down
    down_state_e              state_q, state_d;
    logic [SEG_W-1:0]         seg_q, seg_d, final_q, final_d, last_seg;
    logic [IN_DATA_WIDTH-1:0] data_q, data_d;
    logic [IN_KEEP_WIDTH-1:0] keep_q, keep_d;
    logic                     last_q, last_d, load, is_final;
    logic [USER_WIDTH-1:0]    user_q, user_d;

    axis_last_seg_find #(
      .KEEP_WIDTH(IN_KEEP_WIDTH),
      .SEGS      (RATIO),
      .SEG_W     (SEG_W)
    ) u_last_seg (
      .keep_i(input_axis_tkeep),
      .seg_o (last_seg)
    );

    assign is_final = (seg_q == final_q);

    always_comb begin
      state_d  = state_q;
      seg_d    = seg_q;
      final_d  = final_q;
      data_d   = data_q;
      keep_d   = keep_q;
      last_d   = last_q;
      user_d   = user_q;
      in_ready = 1'b0;
      load     = 1'b0;
      case (state_q)
        ST_IDLE: begin
          in_ready = 1'b1;
          load     = input_axis_tvalid;
        end
        ST_SEND: begin
          if (output_axis_tready) begin
            if (is_final) begin
              // Refill in the same cycle the last segment leaves, so beats stay back-to-back.
              in_ready = 1'b1;
              load     = input_axis_tvalid;
              if (!input_axis_tvalid) state_d = ST_IDLE;
            end else begin
              seg_d = seg_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (load) begin
        state_d = ST_SEND;
        seg_d   = '0;
        data_d  = input_axis_tdata;
        keep_d  = input_axis_tkeep;
        last_d  = input_axis_tlast;
        user_d  = input_axis_tuser;
        final_d = input_axis_tlast ? last_seg : SEG_W'(RATIO - 1);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        seg_q   <= '0;
        final_q <= '0;
        data_q  <= '0;
        keep_q  <= '0;
        last_q  <= 1'b0;
        user_q  <= '0;
      end else begin
        state_q <= state_d;
        seg_q   <= seg_d;
        final_q <= final_d;
        data_q  <= data_d;
        keep_q  <= keep_d;
        last_q  <= last_d;
        user_q  <= user_d;
      end
    end

    assign out_valid = (state_q == ST_SEND);
    assign out_data  = data_q[seg_q*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
    assign out_keep  = keep_q[seg_q*OUT_KEEP_WIDTH +: OUT_KEEP_WIDTH];
    assign out_last  = last_q && is_final;
    assign out_user  = (last_q && is_final) ? user_q : '0;

  end else begin : g_up
    logic                      valid_q, valid_d, last_q, last_d, accept;
    logic [SEG_W-1:0]          seg_q, seg_d;
    logic [OUT_DATA_WIDTH-1:0] data_q, data_d;
    logic [OUT_KEEP_WIDTH-1:0] keep_q, keep_d;
    logic [USER_WIDTH-1:0]     user_q, user_d;

    assign in_ready = !valid_q || output_axis_tready;
    assign accept   = input_axis_tvalid && in_ready;

    always_comb begin
      valid_d = valid_q;
      last_d  = last_q;
      seg_d   = seg_q;
      data_d  = data_q;
      keep_d  = keep_q;
      user_d  = user_q;
      if (valid_q && output_axis_tready) valid_d = 1'b0;
      if (accept) begin
        // The first segment of a word clears the lanes a short frame will not fill.
        if (seg_q == '0) begin
          data_d = '0;
          keep_d = '0;
        end
        data_d[seg_q*IN_DATA_WIDTH +: IN_DATA_WIDTH] = input_axis_tdata;
        keep_d[seg_q*IN_KEEP_WIDTH +: IN_KEEP_WIDTH] = input_axis_tkeep;
        if (seg_q == SEG_W'(RATIO - 1) || input_axis_tlast) begin
          valid_d = 1'b1;
          last_d  = input_axis_tlast;
          user_d  = input_axis_tlast ? input_axis_tuser : '0;
          seg_d   = '0;
        end else begin
          seg_d = seg_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        seg_q   <= '0;
        data_q  <= '0;
        keep_q  <= '0;
        user_q  <= '0;
      end else begin
        valid_q <= valid_d;
        last_q  <= last_d;
        seg_q   <= seg_d;
        data_q  <= data_d;
        keep_q  <= keep_d;
        user_q  <= user_d;
      end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_keep  = keep_q;
    assign out_last  = last_q;
    assign out_user  = user_q;
  end

`ifdef AXIS_WIDTH_CONVERTER_STATS_EN
  logic [31:0] frame_cnt_q, byte_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      byte_cnt_q  <= '0;
    end else if (out_valid && output_axis_tready) begin
      byte_cnt_q <= byte_cnt_q + popcount(POPCOUNT_WIDTH'(out_keep));
      if (out_last) frame_cnt_q <= frame_cnt_q + 32'd1;
    end
  end

  assign stat_frame_count = frame_cnt_q;
  assign stat_byte_count  = byte_cnt_q;
`endif

endmodule

// File: tb/tb_axis_width_converter.sv
// Scoreboard bench: a 64->8 and an 8->64 converter driven with directed and random frames.
module tb_axis_width_converter;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
    logic        fin;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 64 -> 8 instance
  logic [63:0] d_in_data;
  logic [7:0]  d_in_keep;
  logic        d_in_valid, d_in_ready, d_in_last, d_in_user;
  logic [7:0]  d_out_data;
  logic        d_out_keep, d_out_valid, d_out_ready, d_out_last, d_out_user;
  // 8 -> 64 instance
  logic [7:0]  u_in_data;
  logic        u_in_keep, u_in_valid, u_in_ready, u_in_last, u_in_user;
  logic [63:0] u_out_data;
  logic [7:0]  u_out_keep;
  logic        u_out_valid, u_out_ready, u_out_last, u_out_user;
`ifdef AXIS_WIDTH_CONVERTER_STATS_EN
  logic [31:0] d_frames, d_bytes, u_frames, u_bytes;
`endif

  axis_width_converter #(.IN_DATA_WIDTH(64), .OUT_DATA_WIDTH(8), .USER_WIDTH(1)) dut_down (
    .clk(clk), .rst_n(rst_n),
    .input_axis_tdata(d_in_data), .input_axis_tkeep(d_in_keep),
    .input_axis_tvalid(d_in_valid), .input_axis_tready(d_in_ready),
    .input_axis_tlast(d_in_last), .input_axis_tuser(d_in_user),
    .output_axis_tdata(d_out_data), .output_axis_tkeep(d_out_keep),
    .output_axis_tvalid(d_out_valid), .output_axis_tready(d_out_ready),
    .output_axis_tlast(d_out_last), .output_axis_tuser(d_out_user)
`ifdef AXIS_WIDTH_CONVERTER_STATS_EN
    , .stat_frame_count(d_frames), .stat_byte_count(d_bytes)
`endif
  );

  axis_width_converter #(.IN_DATA_WIDTH(8), .OUT_DATA_WIDTH(64), .USER_WIDTH(1)) dut_up (
    .clk(clk), .rst_n(rst_n),
    .input_axis_tdata(u_in_data), .input_axis_tkeep(u_in_keep),
    .input_axis_tvalid(u_in_valid), .input_axis_tready(u_in_ready),
    .input_axis_tlast(u_in_last), .input_axis_tuser(u_in_user),
    .output_axis_tdata(u_out_data), .output_axis_tkeep(u_out_keep),
    .output_axis_tvalid(u_out_valid), .output_axis_tready(u_out_ready),
    .output_axis_tlast(u_out_last), .output_axis_tuser(u_out_user)
`ifdef AXIS_WIDTH_CONVERTER_STATS_EN
    , .stat_frame_count(u_frames), .stat_byte_count(u_bytes)
`endif
  );

  int    errors = 0;
  int    checks = 0;
  beat_t d_exp[$];
  beat_t u_exp[$];
  logic  mon_en = 1'b0;
  logic  no_bubble = 1'b0;
  logic  d_mid_frame = 1'b0;
  int    bubbles = 0;
  int    d_rdy_mode = 0;  // 0 fixed, 1 random, 2 toggle
  int    u_rdy_mode = 0;
  logic [63:0] u_acc_data = '0;
  logic [7:0]  u_acc_keep = '0;
  int          u_acc_n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output-side ready generators.
  initial forever begin
    @(posedge clk);
    #1;
    if (d_rdy_mode == 1) d_out_ready = 1'($urandom_range(0, 1));
    else if (d_rdy_mode == 2) d_out_ready = ~d_out_ready;
    if (u_rdy_mode == 1) u_out_ready = 1'($urandom_range(0, 1));
  end

  // Down-converter monitor: every presented beat (stalled or accepted) must equal the queue head.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (d_out_valid) begin
        if (d_exp.size() == 0) chk("down_unexpected_beat", d_out_valid, 0);
        else begin
          beat_t e;
          e = d_exp[0];
          $display("down beat data=%h keep=%b last=%b user=%b ready=%b", d_out_data, d_out_keep, d_out_last, d_out_user, d_out_ready);
          chk("down_data", d_out_data, e.data);
          chk("down_keep", d_out_keep, e.keep);
          chk("down_last", d_out_last, e.last);
          chk("down_user", d_out_user, e.user);
          chk("down_in_ready", d_in_ready, d_out_ready && e.fin);
          if (d_out_ready) begin
            void'(d_exp.pop_front());
            d_mid_frame = !e.last;
          end
        end
      end else begin
        chk("down_idle_ready", d_in_ready, 1);
        if (no_bubble && d_mid_frame && d_out_ready) bubbles++;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("up_in_ready", u_in_ready, !u_out_valid || u_out_ready);
      if (u_out_valid) begin
        if (u_exp.size() == 0) chk("up_unexpected_word", u_out_valid, 0);
        else begin
          beat_t e;
          e = u_exp[0];
          $display("up word data=%h keep=%h last=%b user=%b ready=%b", u_out_data, u_out_keep, u_out_last, u_out_user, u_out_ready);
          chk("up_data", u_out_data, e.data);
          chk("up_keep", u_out_keep, e.keep);
          chk("up_last", u_out_last, e.last);
          chk("up_user", u_out_user, e.user);
          if (u_out_ready) void'(u_exp.pop_front());
        end
      end
    end
  end

  // Model: a wide beat becomes one narrow beat per byte up to the last byte kept (whole word if not tlast).
  task automatic down_send(input logic [63:0] data, input logic [7:0] keep, input logic last, input logic user);
    int    fin;
    int    n;
    logic  ok;
    beat_t b;
    fin = 7;
    if (last) begin
      fin = 0;
      for (int i = 0; i < 8; i++) if (keep[i]) fin = i;
    end
    for (int i = 0; i <= fin; i++) begin
      b.data = 64'(data[8*i +: 8]);
      b.keep = 8'(keep[i]);
      b.last = last && (i == fin);
      b.user = b.last && user;
      b.fin  = (i == fin);
      d_exp.push_back(b);
    end
    d_in_data = data; d_in_keep = keep; d_in_last = last; d_in_user = user; d_in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk); ok = d_in_ready;
      @(posedge clk); n++;
      if (ok) break;
      if (n > 300) begin chk("down_in_timeout", d_in_ready, 1); break; end
    end
    #1 d_in_valid = 1'b0;
  endtask

  // Model: bytes collect into a word emitted after 8 bytes or on tlast; unused lanes stay zero.
  task automatic up_send(input logic [7:0] data, input logic keep, input logic last, input logic user);
    int    n;
    logic  ok;
    beat_t b;
    u_acc_data[8*u_acc_n +: 8] = data;
    u_acc_keep[u_acc_n] = keep;
    u_acc_n++;
    if (u_acc_n == 8 || last) begin
      b.data = u_acc_data; b.keep = u_acc_keep; b.last = last; b.user = last && user; b.fin = 1'b1;
      u_exp.push_back(b);
      u_acc_data = '0; u_acc_keep = '0; u_acc_n = 0;
    end
    u_in_data = data; u_in_keep = keep; u_in_last = last; u_in_user = user; u_in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk); ok = u_in_ready;
      @(posedge clk); n++;
      if (ok) break;
      if (n > 300) begin chk("up_in_timeout", u_in_ready, 1); break; end
    end
    #1 u_in_valid = 1'b0;
  endtask

  task automatic drain_down();
    int n;
    n = 0;
    while (d_exp.size() != 0 && n < 3000) begin @(posedge clk); n++; end
    chk("down_drain_left", 64'(d_exp.size()), 0);
    #1;
  endtask

  task automatic drain_up();
    int n;
    n = 0;
    while (u_exp.size() != 0 && n < 3000) begin @(posedge clk); n++; end
    chk("up_drain_left", 64'(u_exp.size()), 0);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int          nb;
    logic [7:0]  k;
    d_in_data = '0; d_in_keep = '0; d_in_valid = 0; d_in_last = 0; d_in_user = 0; d_out_ready = 1;
    u_in_data = '0; u_in_keep = 0;  u_in_valid = 0; u_in_last = 0; u_in_user = 0; u_out_ready = 1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_down_valid", d_out_valid, 0);
    chk("rst_down_last", d_out_last, 0);
    chk("rst_down_user", d_out_user, 0);
    chk("rst_down_data", d_out_data, 0);
    chk("rst_down_keep", d_out_keep, 0);
    chk("rst_down_in_ready", d_in_ready, 0);
    chk("rst_up_valid", u_out_valid, 0);
    chk("rst_up_data", u_out_data, 0);
    chk("rst_up_keep", u_out_keep, 0);
    chk("rst_up_in_ready", u_in_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1; mon_en = 1'b1;
    @(negedge clk);
    chk("post_rst_down_ready", d_in_ready, 1);
    chk("post_rst_up_ready", u_in_ready, 1);
    @(posedge clk); #1;

    // 5-byte tlast beat: cd ab cd ab cd, first beat visible the cycle after acceptance
    down_send(64'habcdabcdabcdabcd, 8'h1F, 1'b1, 1'b1);
    @(negedge clk);
    chk("down_latency_valid", d_out_valid, 1);
    drain_down();

    // Two full beats then a 1-byte tlast beat: 17 beats with no bubbles
    no_bubble = 1'b1; bubbles = 0;
    down_send({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0);
    down_send({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0);
    down_send({$urandom, $urandom}, 8'h01, 1'b1, 1'b1);
    drain_down();
    no_bubble = 1'b0;
    chk("down_bubbles", 64'(bubbles), 0);

    // Up-size: 11 22 33 with tlast -> one word 0x332211 keep 0x07
    up_send(8'h11, 1'b1, 1'b0, 1'b0);
    up_send(8'h22, 1'b1, 1'b0, 1'b0);
    up_send(8'h33, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("up_latency_valid", u_out_valid, 1);
    drain_up();

    // Output ready toggling: stalled beats are checked every cycle against the queue head
    d_rdy_mode = 2;
    down_send(64'habcdabcdabcdabcd, 8'h1F, 1'b1, 1'b0);
    drain_down();
    d_rdy_mode = 0; d_out_ready = 1'b1;
    @(posedge clk); #1;

    // Reset during the third of five beats
    down_send(64'habcdabcdabcdabcd, 8'h1F, 1'b1, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 mon_en = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_third_byte", d_out_data, 8'hcd);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_valid", d_out_valid, 0);
    chk("mid_rst_last", d_out_last, 0);
    chk("mid_rst_in_ready", d_in_ready, 0);
    d_exp.delete(); d_mid_frame = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; mon_en = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready_after", d_in_ready, 1);
    @(posedge clk); #1;

    // Frames of 5, 8 and 1 bytes after reset
    down_send(64'h0102030405060708, 8'h1F, 1'b1, 1'b0);
    down_send(64'h1112131415161718, 8'hFF, 1'b1, 1'b1);
    down_send(64'h2122232425262728, 8'h01, 1'b1, 1'b0);
    drain_down();
`ifdef AXIS_WIDTH_CONVERTER_STATS_EN
    chk("stat_frame_count", d_frames, 3);
    chk("stat_byte_count", d_bytes, 14);
`endif

    // Random down-size frames with random output backpressure
    d_rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        k = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
        if (b == nb - 1) k = 8'($urandom);
        down_send({$urandom, $urandom}, k, b == nb - 1, 1'($urandom));
      end
    end
    drain_down();
    d_rdy_mode = 0; d_out_ready = 1'b1;

    // Random up-size frames, occasional empty byte lanes
    u_rdy_mode = 1;
    for (int f = 0; f < 60; f++) begin
      nb = $urandom_range(1, 12);
      for (int b = 0; b < nb; b++) begin
        up_send(8'($urandom), $urandom_range(0, 7) != 0, b == nb - 1, 1'($urandom));
      end
    end
    drain_up();
    u_rdy_mode = 0; u_out_ready = 1'b1;

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
